// File: rtl/seg7_anim_seq_if.sv
// Mode/timing inputs and segment/digit outputs of the 7-segment animation sequencer.
interface seg7_anim_seq_if #(
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned PERIOD_W   = 24
);
    logic                  ena;
    logic [2:0]            mode;
    logic [PERIOD_W-1:0]   period;
    logic                  dir;
    logic                  pause;
    logic                  load;
    logic [6:0]            segments;
    logic [NUM_DIGITS-1:0] digit_en;
    logic                  wrap;

    modport master (
        output ena, mode, period, dir, pause, load,
        input  segments, digit_en, wrap
    );

    modport slave (
        input  ena, mode, period, dir, pause, load,
        output segments, digit_en, wrap
    );
endinterface

// File: rtl/seg7_anim_seq.sv
// Multi-digit 7-segment animation sequencer: frame prescaler, BCD/pattern frames, digit scan.
// Optional build macro SEG7_ZERO_BLANK_EN blanks leading zeros in BCD mode (mode 0).
module seg7_anim_seq #(
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned PERIOD_W   = 24,
    parameter int unsigned MUX_DIV_W  = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    seg7_anim_seq_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PERIOD_W-1:0]        r_presc;
    logic [2:0]                 r_frame;
    logic [NUM_DIGITS-1:0][3:0] r_bcd;
    logic [2:0]                 r_mode;
    logic [MUX_DIV_W-1:0]       r_scan_cnt;
    logic [IDX_W-1:0]           r_scan_idx;
    logic [6:0]                 r_segments;
    logic [NUM_DIGITS-1:0]      r_digit_en;
    logic                       r_wrap;

    logic [2:0]                 w_len;
    logic [3:0]                 w_disp_frame;
    logic [NUM_DIGITS-1:0][3:0] w_bcd_next;
    logic                       w_bcd_wrap;
    logic [2:0]                 w_frame_next;
    logic                       w_frame_wrap;
    logic                       w_wrap_evt;
    logic [NUM_DIGITS-1:0]      w_blank;
    logic [3:0]                 w_digit;
    logic [6:0]                 w_seg;
    logic [IDX_W-1:0]           w_idx_next;
    logic                       w_scan_ovf;

    function automatic logic [6:0] bcd_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    function automatic logic [6:0] frame_pattern(input logic [2:0] m, input logic [3:0] f);
        logic [6:0] p;
        p = 7'h00;
        case (m)
            3'd1: case (f)
                4'd0: p = 7'h01; 4'd1: p = 7'h02; 4'd2: p = 7'h04; 4'd3: p = 7'h08;
                4'd4: p = 7'h10; 4'd5: p = 7'h20; 4'd6: p = 7'h40; default: p = 7'h00;
            endcase
            3'd2: case (f)
                4'd0: p = 7'h41; 4'd1: p = 7'h22; 4'd2: p = 7'h14; 4'd3: p = 7'h08;
                4'd4: p = 7'h14; 4'd5: p = 7'h22; 4'd6: p = 7'h41; default: p = 7'h00;
            endcase
            3'd3: case (f)
                4'd0: p = 7'h41; 4'd1: p = 7'h22; 4'd2: p = 7'h14; 4'd3: p = 7'h08;
                4'd4: p = 7'h04; 4'd5: p = 7'h02; 4'd6: p = 7'h01; default: p = 7'h00;
            endcase
            3'd4: case (f)
                4'd0: p = 7'h0C; 4'd1: p = 7'h06; 4'd2: p = 7'h03;
                4'd3: p = 7'h21; 4'd4: p = 7'h30; 4'd5: p = 7'h18; default: p = 7'h00;
            endcase
            3'd5: case (f)
                4'd0: p = 7'h0C; 4'd1: p = 7'h18; 4'd2: p = 7'h30;
                4'd3: p = 7'h21; 4'd4: p = 7'h03; 4'd5: p = 7'h06; default: p = 7'h00;
            endcase
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    // Frame length for the pattern modes; mode 0 uses the BCD counter instead.
    always_comb begin
        case (r_mode)
            3'd1, 3'd2, 3'd3: w_len = 3'd7;
            3'd4, 3'd5:       w_len = 3'd6;
            default:          w_len = 3'd1;
        endcase
    end

    // Per-digit phase offset: (frame + scan index) mod L, index never exceeds 7.
    always_comb begin
        w_disp_frame = {1'b0, r_frame} + 4'(r_scan_idx);
        if (w_disp_frame >= {1'b0, w_len}) w_disp_frame = w_disp_frame - {1'b0, w_len};
        if (w_disp_frame >= {1'b0, w_len}) w_disp_frame = w_disp_frame - {1'b0, w_len};
    end

    // Ripple BCD increment/decrement; a carry out of the top digit is the wrap.
    always_comb begin : bcd_step
        logic v_carry;
        v_carry    = 1'b1;
        w_bcd_next = r_bcd;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (v_carry) begin
                if (!bus.dir) begin
                    if (r_bcd[i] == 4'd9) begin
                        w_bcd_next[i] = 4'd0;
                    end else begin
                        w_bcd_next[i] = r_bcd[i] + 4'd1;
                        v_carry       = 1'b0;
                    end
                end else begin
                    if (r_bcd[i] == 4'd0) begin
                        w_bcd_next[i] = 4'd9;
                    end else begin
                        w_bcd_next[i] = r_bcd[i] - 4'd1;
                        v_carry       = 1'b0;
                    end
                end
            end
        end
        w_bcd_wrap = v_carry;
    end

    always_comb begin
        w_frame_next = r_frame;
        w_frame_wrap = 1'b0;
        if (!bus.dir) begin
            if (r_frame >= w_len - 3'd1) begin
                w_frame_next = 3'd0;
                w_frame_wrap = 1'b1;
            end else begin
                w_frame_next = r_frame + 3'd1;
            end
        end else begin
            if (r_frame == 3'd0) begin
                w_frame_next = w_len - 3'd1;
                w_frame_wrap = 1'b1;
            end else begin
                w_frame_next = r_frame - 3'd1;
            end
        end
    end

    assign w_wrap_evt = (r_mode == 3'd0) ? w_bcd_wrap : w_frame_wrap;

`ifdef SEG7_ZERO_BLANK_EN
    // Blank every digit above the most significant non-zero digit; digit 0 always shows.
    always_comb begin : blank_gen
        logic v_nz;
        v_nz    = 1'b0;
        w_blank = '0;
        for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
            v_nz       = v_nz | (r_bcd[i] != 4'd0);
            w_blank[i] = ~v_nz;
        end
    end
`else
    assign w_blank = '0;
`endif

    assign w_digit = r_bcd[r_scan_idx];

    always_comb begin
        if (r_mode == 3'd0) begin
            w_seg = w_blank[r_scan_idx] ? 7'h00 : bcd_pattern(w_digit);
        end else begin
            w_seg = frame_pattern(r_mode, w_disp_frame);
        end
    end

    assign w_scan_ovf = &r_scan_cnt;
    assign w_idx_next = (r_scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_scan_idx + IDX_W'(1);

    // Outputs are registered from the current scan index and frames so digit and pattern move together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc    <= '0;
            r_frame    <= '0;
            r_bcd      <= '0;
            r_mode     <= '0;
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
            r_segments <= '0;
            r_digit_en <= '0;
            r_wrap     <= 1'b0;
        end else if (bus.ena) begin
            r_scan_cnt <= r_scan_cnt + MUX_DIV_W'(1);
            if (w_scan_ovf) r_scan_idx <= w_idx_next;
            r_segments <= w_seg;
            r_digit_en <= NUM_DIGITS'(1) << r_scan_idx;
            r_wrap     <= 1'b0;
            if (bus.load) begin
                r_presc <= '0;
                r_frame <= '0;
                r_bcd   <= '0;
            end else if (bus.mode != r_mode) begin
                r_mode  <= bus.mode;
                r_presc <= '0;
                r_frame <= '0;
                r_bcd   <= '0;
            end else if (!bus.pause) begin
                if (r_presc >= bus.period) begin
                    r_presc <= '0;
                    r_wrap  <= w_wrap_evt;
                    if (r_mode == 3'd0) r_bcd   <= w_bcd_next;
                    else                r_frame <= w_frame_next;
                end else begin
                    r_presc <= r_presc + PERIOD_W'(1);
                end
            end
        end
    end

    assign bus.segments = r_segments;
    assign bus.digit_en = r_digit_en;
    assign bus.wrap     = r_wrap;
endmodule

// File: tb/tb_seg7_anim_seq.sv
// Scoreboard bench for seg7_anim_seq: stimulus pushes expected outputs, a monitor compares them.
module tb_seg7_anim_seq;
    localparam int unsigned ND = 2;
    localparam int unsigned PW = 8;
    localparam int unsigned MW = 3;

`ifdef SEG7_ZERO_BLANK_EN
    localparam logic [6:0] LEAD_ZERO = 7'h00;
`else
    localparam logic [6:0] LEAD_ZERO = 7'h3F;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg7_anim_seq_if #(.NUM_DIGITS(ND), .PERIOD_W(PW)) bus ();

    seg7_anim_seq #(.NUM_DIGITS(ND), .PERIOD_W(PW), .MUX_DIV_W(MW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         due;
        logic [6:0] seg;
        logic [1:0] den;
        logic       wrap;
        bit         c_seg;
        bit         c_den;
        bit         c_wrap;
        bit         use_cond;
        logic [1:0] cond_den;
        string      name;
    } item_t;

    item_t q[$];
    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int wrap_seen = 0;

    logic [6:0] p_tab [6][10] = '{
        '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F},
        '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h00, 7'h00, 7'h00},
        '{7'h41, 7'h22, 7'h14, 7'h08, 7'h14, 7'h22, 7'h41, 7'h00, 7'h00, 7'h00},
        '{7'h41, 7'h22, 7'h14, 7'h08, 7'h04, 7'h02, 7'h01, 7'h00, 7'h00, 7'h00},
        '{7'h0C, 7'h06, 7'h03, 7'h21, 7'h30, 7'h18, 7'h00, 7'h00, 7'h00, 7'h00},
        '{7'h0C, 7'h18, 7'h30, 7'h21, 7'h03, 7'h06, 7'h00, 7'h00, 7'h00, 7'h00}
    };

    // Monitor: compare every item due at this edge, sampled 1 time unit after it.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (bus.wrap === 1'b1) wrap_seen = wrap_seen + 1;
        for (int i = 0; i < q.size(); ) begin
            if (q[i].due < cyc) begin
                n_vec = n_vec + 1;
                n_err = n_err + 1;
                $display("FAIL %s: check missed at cycle %0d, want cycle %0d", q[i].name, cyc, q[i].due);
                q.delete(i);
            end else if (q[i].due == cyc) begin
                if (!(q[i].use_cond && bus.digit_en !== q[i].cond_den)) begin
                    n_vec = n_vec + 1;
                    if ((q[i].c_seg  && bus.segments !== q[i].seg) ||
                        (q[i].c_den  && bus.digit_en !== q[i].den) ||
                        (q[i].c_wrap && bus.wrap     !== q[i].wrap)) begin
                        n_err = n_err + 1;
                        $display("FAIL %s @%0d: got seg=%h den=%b wrap=%b, want seg=%h den=%b wrap=%b (chk %0d%0d%0d)",
                                 q[i].name, cyc, bus.segments, bus.digit_en, bus.wrap,
                                 q[i].seg, q[i].den, q[i].wrap, q[i].c_seg, q[i].c_den, q[i].c_wrap);
                    end
                end
                q.delete(i);
            end else begin
                i++;
            end
        end
    end

    // Expected-behaviour state tracked by the stimulus side.
    int m_mode, m_f, m_v, m_presc, m_act;
    logic [6:0] e_seg;
    logic [1:0] e_den;
    logic       e_wrap;

    function automatic int len_of(input int m);
        if (m == 0) return 10;
        if (m <= 3) return 7;
        if (m <= 5) return 6;
        return 1;
    endfunction

    function automatic logic [6:0] exp_seg(input int idx);
        logic [6:0] s;
        int d;
        if (m_mode == 0) begin
            d = (idx == 0) ? (m_v % 10) : ((m_v / 10) % 10);
            s = p_tab[0][d];
`ifdef SEG7_ZERO_BLANK_EN
            if (idx == 1 && m_v < 10) s = 7'h00;
`endif
        end else if (m_mode >= 6) begin
            s = 7'h00;
        end else begin
            s = p_tab[m_mode][(m_f + idx) % len_of(m_mode)];
        end
        return s;
    endfunction

    task automatic push_item(input int k, input string name, input logic [6:0] seg, input logic [1:0] den,
                             input logic wr, input bit cs, input bit cd, input bit cw,
                             input bit uc, input logic [1:0] cden);
        item_t it;
        it.due = cyc + k; it.seg = seg; it.den = den; it.wrap = wr;
        it.c_seg = cs; it.c_den = cd; it.c_wrap = cw; it.use_cond = uc; it.cond_den = cden;
        it.name = name;
        q.push_back(it);
    endtask

    // One clock: derive the expected output of the next edge, push it, then advance the model.
    task automatic cyc1(input string name);
        int idx;
        if (!rst_n) begin
            e_seg = 7'h00; e_den = 2'b00; e_wrap = 1'b0;
            m_mode = 0; m_f = 0; m_v = 0; m_presc = 0; m_act = 0;
        end else if (bus.ena) begin
            idx    = (m_act / 8) % 2;
            e_seg  = exp_seg(idx);
            e_den  = (idx == 0) ? 2'b01 : 2'b10;
            e_wrap = 1'b0;
            if (bus.load) begin
                m_f = 0; m_v = 0; m_presc = 0;
            end else if (int'(bus.mode) != m_mode) begin
                m_mode = int'(bus.mode); m_f = 0; m_v = 0; m_presc = 0;
            end else if (!bus.pause) begin
                if (m_presc >= int'(bus.period)) begin
                    m_presc = 0;
                    if (m_mode == 0) begin
                        if (!bus.dir) begin
                            if (m_v == 99) begin m_v = 0; e_wrap = 1'b1; end else m_v = m_v + 1;
                        end else begin
                            if (m_v == 0) begin m_v = 99; e_wrap = 1'b1; end else m_v = m_v - 1;
                        end
                    end else begin
                        if (!bus.dir) begin
                            if (m_f == len_of(m_mode) - 1) begin m_f = 0; e_wrap = 1'b1; end else m_f = m_f + 1;
                        end else begin
                            if (m_f == 0) begin m_f = len_of(m_mode) - 1; e_wrap = 1'b1; end else m_f = m_f - 1;
                        end
                    end
                end else begin
                    m_presc = m_presc + 1;
                end
            end
            m_act = m_act + 1;
        end
        push_item(1, name, e_seg, e_den, e_wrap, 1, 1, 1, 0, 2'b00);
        @(negedge clk);
    endtask

    task automatic check_now(input string name, input int got, input int want);
        n_vec = n_vec + 1;
        if (got != want) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        int w0;
        rst_n = 1'b0;
        bus.ena = 1'b1; bus.mode = 3'd0; bus.period = 8'd3;
        bus.dir = 1'b0; bus.pause = 1'b0; bus.load = 1'b0;
        @(negedge clk);
        repeat (3) cyc1("reset");

        // BCD forward, period 3: first tick on the 4th edge after release.
        rst_n = 1'b1;
        push_item(1, "first_out", 7'h3F, 2'b01, 1'b0, 1, 1, 1, 0, 2'b00);
        push_item(4, "pre_tick",  7'h3F, 2'b01, 1'b0, 1, 1, 0, 0, 2'b00);
        push_item(5, "digit0_06", 7'h06, 2'b01, 1'b0, 1, 1, 0, 0, 2'b00);
        push_item(9, "digit1_3F", 7'h3F, 2'b10, 1'b0, 1, 1, 0, 0, 2'b00);
        repeat (20) cyc1("bcd_fwd");

        bus.period = 8'd0;
        w0 = wrap_seen;
        repeat (100) cyc1("bcd_100");
        check_now("bcd_single_wrap", wrap_seen - w0, 1);

        // Reverse from 00: one tick gives 99 with a wrap.
        bus.load = 1'b1;
        cyc1("load0");
        bus.load = 1'b0; bus.dir = 1'b1;
        push_item(1, "rev_wrap", 7'h00, 2'b00, 1'b1, 0, 0, 1, 0, 2'b00);
        for (int k = 2; k <= 17; k++) push_item(k, "rev_99", 7'h6F, 2'b00, 1'b0, 1, 0, 0, 0, 2'b00);
        cyc1("rev_tick");
        bus.pause = 1'b1;
        repeat (17) cyc1("rev_hold");
        bus.pause = 1'b0; bus.dir = 1'b0;

        // Mode 4: digit 1 runs one frame ahead, wrap every 6 ticks.
        bus.mode = 3'd4;
        cyc1("mode4_chg");
        push_item(1, "m4_d0", 7'h0C, 2'b01, 1'b0, 1, 0, 0, 1, 2'b01);
        push_item(1, "m4_d1", 7'h06, 2'b10, 1'b0, 1, 0, 0, 1, 2'b10);
        w0 = wrap_seen;
        repeat (36) cyc1("mode4_run");
        check_now("mode4_wraps", wrap_seen - w0, 6);

        // Mode 1 to frame 5, then switch to mode 2.
        bus.mode = 3'd1;
        cyc1("mode1_chg");
        repeat (5) cyc1("mode1_run");
        bus.mode = 3'd2;
        push_item(1, "m2_nowrap",  7'h00, 2'b00, 1'b0, 0, 0, 1, 0, 2'b00);
        push_item(2, "m2_nowrap2", 7'h00, 2'b00, 1'b0, 0, 0, 1, 0, 2'b00);
        push_item(2, "m2_d0",      7'h41, 2'b01, 1'b0, 1, 0, 0, 1, 2'b01);
        push_item(2, "m2_d1",      7'h22, 2'b10, 1'b0, 1, 0, 0, 1, 2'b10);
        cyc1("mode2_chg");
        repeat (3) cyc1("mode2_run");
        bus.pause = 1'b1;
        repeat (40) cyc1("pause");
        bus.pause = 1'b0;

        // Mode 3 with load, enable gap and reverse direction.
        bus.mode = 3'd3; bus.period = 8'd1;
        cyc1("mode3_chg");
        repeat (9) cyc1("mode3_run");
        bus.load = 1'b1;
        repeat (3) cyc1("load_hold");
        bus.load = 1'b0;
        repeat (5) cyc1("after_load");
        bus.ena = 1'b0;
        repeat (50) cyc1("ena_off");
        bus.ena = 1'b1;
        repeat (10) cyc1("ena_on");
        bus.mode = 3'd5; bus.period = 8'd0;
        repeat (6) cyc1("mode5_fwd");
        bus.dir = 1'b1;
        repeat (15) cyc1("mode5_rev");
        bus.mode = 3'd6;
        repeat (4) cyc1("mode6_blank");

        // Synchronous reset mid-run.
        rst_n = 1'b0;
        push_item(1, "rst_mid", 7'h00, 2'b00, 1'b0, 1, 1, 1, 0, 2'b00);
        repeat (2) cyc1("rst_mid_hold");

        // Value 07: leading-zero handling on digit 1.
        rst_n = 1'b1; bus.mode = 3'd0; bus.dir = 1'b0;
        bus.load = 1'b1;
        cyc1("zb_load");
        bus.load = 1'b0;
        repeat (7) cyc1("zb_count");
        bus.pause = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            push_item(k, "zb_d0", 7'h07,     2'b01, 1'b0, 1, 0, 0, 1, 2'b01);
            push_item(k, "zb_d1", LEAD_ZERO, 2'b10, 1'b0, 1, 0, 0, 1, 2'b10);
        end
        repeat (17) cyc1("zb_hold");
        bus.pause = 1'b0;

        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) begin
            n_vec = n_vec + 1;
            n_err = n_err + 1;
            $display("FAIL drain: %0d items left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
